mips_multicycle_controller: RTL

Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks, replacing the single-cycle main/ALU decoder pair. It sits beside the multicycle datapath, which has a shared instruction/data memory. It drives the datapath mux selects and write enables and gates PC updates on a memory-ready handshake. It adds `addi`, `j` and an illegal-opcode flag, and has an optional `bne`.

---
 rtl/mips_multicycle_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/wb.
// Optional bne support is enabled by defining BNE_EN.
module mips_multicycle_controller #(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  state_t     state;
  state_t     nxt;
  logic       op_bad;
  logic       fn_bad;
  logic       pcwrite;
  logic       branch;
  logic       branch_ne;
  logic       irw;
  logic       rw;
  logic       mw;
  logic [1:0] aluop;
  logic [2:0] alu3;

  // state register, synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  // next-state logic; memory states stall until mem_ready
  always_comb begin
    nxt    = S_FETCH;
    op_bad = 1'b0;
    case (state)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYP:      nxt = S_RTYPEEX;
          OP_BEQ:       nxt = S_BEQEX;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JEX;
`ifdef BNE_EN
          OP_BNE:       nxt = S_BNEEX;
`endif
          default: begin
            nxt    = S_FETCH;
            op_bad = 1'b1;
          end
        endcase
      end
      S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: nxt = S_RTYPEWB;
      S_RTYPEWB: nxt = S_FETCH;
      S_BEQEX:   nxt = S_FETCH;
      S_ADDIEX:  nxt = S_ADDIWB;
      S_ADDIWB:  nxt = S_FETCH;
      S_JEX:     nxt = S_FETCH;
      S_BNEEX:   nxt = S_FETCH;
      default:   nxt = S_FETCH;
    endcase
  end

  // Moore control word per state; unlisted outputs stay 0
  always_comb begin
    iord      = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    rw        = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    aluop     = 2'b00;
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irw     = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        rw       = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        mw   = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regdst = 1'b1;
        rw     = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef BNE_EN
      S_BNEEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch_ne = 1'b1;
      end
`endif
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: rw = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode; unknown R-type funct falls back to add
  always_comb begin
    alu3   = 3'b010;
    fn_bad = 1'b0;
    case (aluop)
      2'b00: alu3 = 3'b010;
      2'b01: alu3 = 3'b110;
      default: begin
        case (funct)
          6'b100000: alu3 = 3'b010;
          6'b100010: alu3 = 3'b110;
          6'b100100: alu3 = 3'b000;
          6'b100101: alu3 = 3'b001;
          6'b101010: alu3 = 3'b111;
          default: begin
            alu3   = 3'b010;
            fn_bad = 1'b1;
          end
        endcase
      end
    endcase
  end

  // write enables and flags are suppressed while reset is held
  always_comb begin
    pcen = (pcwrite | (branch & zero) | (branch_ne & ~zero)) & ~reset;
    irwrite  = irw & ~reset;
    regwrite = rw & ~reset;
    memwrite = mw & ~reset;
    illegal  = ((state == S_DECODE) & op_bad
              | (state == S_RTYPEEX) & fn_bad) & ~reset;
  end

  assign alucontrol = ALUCTRL_W'(alu3);
  assign state_o    = state;

endmodule
